// File: rtl/vga_pkg.sv
// Shared constants for the VGA video path: default 640x480@60 timing, coordinate width,
// and the layout of the 64-bit ship-position vector read by the renderers.
package vga_pkg;

   localparam int COORD_W   = 10;
   localparam int COORD_MAX = 1 << COORD_W;

   localparam int DIV_DEF    = 2;
   localparam int H_VIS_DEF  = 640;
   localparam int H_FP_DEF   = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;
   localparam int V_VIS_DEF  = 480;
   localparam int V_FP_DEF   = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;

   // Ship vector: sixteen 4-bit fields, field i at bit offset 4*i.
   localparam int NAVES_W  = 64;
   localparam int CAMPO_W  = 4;
   localparam int N_CAMPOS = NAVES_W / CAMPO_W;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [NAVES_W-1:0] naves_t;

   function automatic int campo_ofs(input int idx);
      return idx * CAMPO_W;
   endfunction

endpackage

// File: rtl/vga_sincronismo_if.sv
// Timing-generator outputs consumed by the renderers; the frame-stable ship vector
// is carried only when VGA_SINC_QUADRO_EN is defined.
interface vga_sincronismo_if;
   import vga_pkg::*;

   logic   hsync;
   logic   vsync;
   logic   areaAtiva;
   coord_t coluna;
   coord_t linha;
   logic   pixelEn;
   logic   inicioQuadro;
   logic   fimVisivel;
`ifdef VGA_SINC_QUADRO_EN
   naves_t posicoesIn;
   naves_t posicoesQuadro;
`endif

   modport master (
      output hsync, vsync, areaAtiva, coluna, linha, pixelEn, inicioQuadro, fimVisivel
`ifdef VGA_SINC_QUADRO_EN
      , input posicoesIn
      , output posicoesQuadro
`endif
   );

   modport slave (
      input hsync, vsync, areaAtiva, coluna, linha, pixelEn, inicioQuadro, fimVisivel
`ifdef VGA_SINC_QUADRO_EN
      , output posicoesIn
      , input posicoesQuadro
`endif
   );

endinterface

// File: rtl/vga_contador.sv
// Modulo-N counter with enable. Exposes the next value so callers can register
// decodes on the same edge the count changes; wrap flags the enabled N-1 -> 0 step.
module vga_contador
   import vga_pkg::*;
#(
   parameter int N = 800,
   parameter int W = COORD_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] valor,
   output logic [W-1:0] proximo,
   output logic         wrap
);

   localparam logic [W-1:0] ULTIMO = W'(N - 1);

   always_comb begin
      wrap    = en && (valor == ULTIMO);
      proximo = valor;
      if (wrap)
         proximo = '0;
      else if (en)
         proximo = valor + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         valor <= '0;
      else
         valor <= proximo;
   end

endmodule

// File: rtl/vga_sincronismo.sv
// VGA timing generator: pixel-rate divider, column/line counters and registered sync/qualifier decode.
// With VGA_SINC_QUADRO_EN the ship vector is latched at the start of vertical blanking.
module vga_sincronismo
   import vga_pkg::*;
#(
   parameter int DIV    = DIV_DEF,
   parameter int H_VIS  = H_VIS_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_VIS  = V_VIS_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF
) (
   input  logic               clk,
   input  logic               rst,
   vga_sincronismo_if.master  vga
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DIV_W = 5;

   localparam logic [DIV_W-1:0] DIV_ULT = DIV_W'(DIV - 1);
   localparam coord_t H_VIS_C = COORD_W'(H_VIS);
   localparam coord_t V_VIS_C = COORD_W'(V_VIS);
   localparam coord_t HS_INI  = COORD_W'(H_VIS + H_FP);
   localparam coord_t HS_FIM  = COORD_W'(H_VIS + H_FP + H_SYNC - 1);
   localparam coord_t VS_INI  = COORD_W'(V_VIS + V_FP);
   localparam coord_t VS_FIM  = COORD_W'(V_VIS + V_FP + V_SYNC - 1);

   if (H_TOT > COORD_MAX || V_TOT > COORD_MAX) begin : g_tot_invalido
      $error("vga_sincronismo: H_TOT or V_TOT exceeds 1024");
   end
   if (DIV < 1 || DIV > 16) begin : g_div_invalido
      $error("vga_sincronismo: DIV outside 1..16");
   end

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   coord_t           h_prox;
   coord_t           v_prox;
   logic             h_wrap;
   logic             v_wrap;
   logic             fim_prox;

   assign tick = (div_cnt == DIV_ULT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   vga_contador #(.N(H_TOT), .W(COORD_W)) u_horizontal (
      .clk     (clk),
      .rst     (rst),
      .en      (tick),
      .valor   (vga.coluna),
      .proximo (h_prox),
      .wrap    (h_wrap)
   );

   // h_wrap already includes the tick, so the line counter steps once per line.
   vga_contador #(.N(V_TOT), .W(COORD_W)) u_vertical (
      .clk     (clk),
      .rst     (rst),
      .en      (h_wrap),
      .valor   (vga.linha),
      .proximo (v_prox),
      .wrap    (v_wrap)
   );

   assign fim_prox = h_wrap && (v_prox == V_VIS_C);

   // Levels only update on ticks so the post-reset (0,0) stays blanked until the first pixel step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga.hsync        <= 1'b1;
         vga.vsync        <= 1'b1;
         vga.areaAtiva    <= 1'b0;
         vga.pixelEn      <= 1'b0;
         vga.inicioQuadro <= 1'b0;
         vga.fimVisivel   <= 1'b0;
      end else begin
         vga.pixelEn      <= tick;
         vga.inicioQuadro <= v_wrap;
         vga.fimVisivel   <= fim_prox;
         if (tick) begin
            vga.hsync     <= !((h_prox >= HS_INI) && (h_prox <= HS_FIM));
            vga.vsync     <= !((v_prox >= VS_INI) && (v_prox <= VS_FIM));
            vga.areaAtiva <= (h_prox < H_VIS_C) && (v_prox < V_VIS_C);
         end
      end
   end

`ifdef VGA_SINC_QUADRO_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vga.posicoesQuadro <= '0;
      else if (fim_prox)
         vga.posicoesQuadro <= vga.posicoesIn;
   end
`endif

endmodule

// File: tb/tb_vga_sincronismo.sv
// Bench for vga_sincronismo on a reduced 25x17 raster (DIV=2 and DIV=1 instances) so whole frames fit a short run.
module tb_vga_sincronismo;
   import vga_pkg::*;

   localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 3;
   localparam int V_VIS = 10, V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int H_TOT = 25, V_TOT = 17;
   localparam int QUADRO = 850;          // H_TOT*V_TOT*2 clk per frame on the DIV=2 instance
   localparam logic [63:0] V1 = 64'h0000_0001_2345_6781;
   localparam logic [63:0] V2 = 64'hA5A5_0000_FFFF_1234;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   vga_sincronismo_if va ();
   vga_sincronismo_if vb ();

   vga_sincronismo #(.DIV(2), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
                     .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)) u_a (
      .clk (clk),
      .rst (rst),
      .vga (va)
   );

   vga_sincronismo #(.DIV(1), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
                     .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)) u_b (
      .clk (clk),
      .rst (rst),
      .vga (vb)
   );

   task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
      n_chk++;
      if (obs !== esp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, esp);
      end
   endtask

   task automatic ciclo();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic verifica_reset(input string fase);
      verifica({fase, "_coluna"}, 64'(va.coluna), 64'd0);
      verifica({fase, "_linha"}, 64'(va.linha), 64'd0);
      verifica({fase, "_hsync"}, 64'(va.hsync), 64'd1);
      verifica({fase, "_vsync"}, 64'(va.vsync), 64'd1);
      verifica({fase, "_area"}, 64'(va.areaAtiva), 64'd0);
      verifica({fase, "_pixelEn"}, 64'(va.pixelEn), 64'd0);
      verifica({fase, "_inicio"}, 64'(va.inicioQuadro), 64'd0);
      verifica({fase, "_fim"}, 64'(va.fimVisivel), 64'd0);
`ifdef VGA_SINC_QUADRO_EN
      verifica({fase, "_posicoes"}, va.posicoesQuadro, 64'd0);
`endif
   endtask

   initial begin
      int k, ticks, p, col, lin;
      int err_col, err_lin, err_area, err_pix, err_hs, err_vs;
      int n_hs, bad_hs, hs_cnt, n_vs, bad_vs, vs_cnt;
      int ini1, ini2, fim1, n_ini, n_fim, n_ativo, viol, viol_pulso;
      int b_pix_low, b_lin1, b_lin2;
      logic prev_hs, prev_vs;
      bit achou;

      err_col = 0; err_lin = 0; err_area = 0; err_pix = 0; err_hs = 0; err_vs = 0;
      n_hs = 0; bad_hs = 0; hs_cnt = 0; n_vs = 0; bad_vs = 0; vs_cnt = 0;
      ini1 = -1; ini2 = -1; fim1 = -1; n_ini = 0; n_fim = 0; n_ativo = 0;
      viol = 0; viol_pulso = 0; b_pix_low = 0; b_lin1 = -1; b_lin2 = -1;
      prev_hs = 1'b1; prev_vs = 1'b1;
`ifdef VGA_SINC_QUADRO_EN
      va.posicoesIn = '0;
      vb.posicoesIn = '0;
`endif

      rst = 1'b1;
      repeat (3) @(negedge clk);
      verifica_reset("rst0");
      rst = 1'b0;

      for (k = 1; k <= 2 * QUADRO + 4; k++) begin
         ciclo();
         ticks = k / 2;
         p     = ticks % (H_TOT * V_TOT);
         col   = p % H_TOT;
         lin   = p / H_TOT;

         if (int'(va.coluna) != col) err_col++;
         if (int'(va.linha) != lin) err_lin++;
         if (va.areaAtiva !== (ticks > 0 && col < H_VIS && lin < V_VIS)) err_area++;
         if (va.pixelEn !== (k % 2 == 0)) err_pix++;
         if (va.hsync !== !(col >= 18 && col <= 21)) err_hs++;
         if (va.vsync !== !(lin >= 12 && lin <= 13)) err_vs++;

         if (!va.hsync) begin
            if (prev_hs) begin
               hs_cnt = 1;
               if (int'(va.coluna) != 18) bad_hs++;
            end else hs_cnt++;
         end else if (!prev_hs) begin
            n_hs++;
            if (hs_cnt != 8) bad_hs++;
         end
         prev_hs = va.hsync;

         if (!va.vsync) begin
            if (prev_vs) begin
               vs_cnt = 1;
               if (int'(va.linha) != 12) bad_vs++;
            end else vs_cnt++;
         end else if (!prev_vs) begin
            n_vs++;
            if (vs_cnt != 100) bad_vs++;
         end
         prev_vs = va.vsync;

         if (va.inicioQuadro) begin
            n_ini++;
            if (ini1 < 0) ini1 = k; else if (ini2 < 0) ini2 = k;
         end
         if (va.fimVisivel) begin
            n_fim++;
            if (fim1 < 0) fim1 = k;
         end
         if (k >= QUADRO && k < 2 * QUADRO && va.areaAtiva && va.pixelEn) n_ativo++;
         if (va.areaAtiva && (int'(va.coluna) >= H_VIS || int'(va.linha) >= V_VIS)) viol++;
         if ((va.inicioQuadro || va.fimVisivel) && !va.pixelEn) viol_pulso++;

         if (!vb.pixelEn) b_pix_low++;
         if (vb.pixelEn && vb.coluna == '0) begin
            if (b_lin1 < 0) b_lin1 = k; else if (b_lin2 < 0) b_lin2 = k;
         end

         case (k)
            1: begin
               verifica("k1_coluna", 64'(va.coluna), 64'd0);
               verifica("k1_area", 64'(va.areaAtiva), 64'd0);
               verifica("k1_pixelEn", 64'(va.pixelEn), 64'd0);
               verifica("div1_k1_coluna", 64'(vb.coluna), 64'd1);
               verifica("div1_k1_area", 64'(vb.areaAtiva), 64'd1);
            end
            2: begin
               verifica("k2_coluna", 64'(va.coluna), 64'd1);
               verifica("k2_area", 64'(va.areaAtiva), 64'd1);
               verifica("k2_pixelEn", 64'(va.pixelEn), 64'd1);
            end
            3: begin
               verifica("k3_coluna_hold", 64'(va.coluna), 64'd1);
               verifica("k3_pixelEn", 64'(va.pixelEn), 64'd0);
            end
            498: verifica("pre_fim_pos", 64'({va.coluna, va.linha}), 64'({10'd24, 10'd9}));
            500: begin
               verifica("fim_pos", 64'({va.coluna, va.linha}), 64'({10'd0, 10'd10}));
               verifica("fim_pulse", 64'(va.fimVisivel), 64'd1);
               verifica("fim_area", 64'(va.areaAtiva), 64'd0);
            end
            501: verifica("fim_one_clk", 64'(va.fimVisivel), 64'd0);
            848: verifica("pre_wrap_pos", 64'({va.coluna, va.linha}), 64'({10'd24, 10'd16}));
            850: begin
               verifica("wrap_pos", 64'({va.coluna, va.linha}), 64'd0);
               verifica("wrap_inicio", 64'(va.inicioQuadro), 64'd1);
               verifica("wrap_area", 64'(va.areaAtiva), 64'd1);
            end
            default: ;
         endcase

`ifdef VGA_SINC_QUADRO_EN
         if (k == 100) va.posicoesIn = V1;
         if (k == 499) verifica("pos_hold_visible", va.posicoesQuadro, 64'd0);
         if (k == 500) verifica("pos_load_fim", va.posicoesQuadro, V1);
         if (k == 550) va.posicoesIn = V2;
         if (k == 1349) verifica("pos_hold_blank_change", va.posicoesQuadro, V1);
         if (k == 1350) verifica("pos_load_next_fim", va.posicoesQuadro, V2);
`endif
      end

      verifica("model_coluna_errs", 64'(err_col), 64'd0);
      verifica("model_linha_errs", 64'(err_lin), 64'd0);
      verifica("model_area_errs", 64'(err_area), 64'd0);
      verifica("model_pixelEn_errs", 64'(err_pix), 64'd0);
      verifica("model_hsync_errs", 64'(err_hs), 64'd0);
      verifica("model_vsync_errs", 64'(err_vs), 64'd0);
      verifica("hsync_runs", 64'(n_hs), 64'd34);
      verifica("hsync_bad_runs", 64'(bad_hs), 64'd0);
      verifica("vsync_runs", 64'(n_vs), 64'd2);
      verifica("vsync_bad_runs", 64'(bad_vs), 64'd0);
      verifica("inicio_first_k", 64'(ini1), 64'd850);
      verifica("inicio_period", 64'(ini2 - ini1), 64'd850);
      verifica("inicio_count", 64'(n_ini), 64'd2);
      verifica("fim_first_k", 64'(fim1), 64'd500);
      verifica("fim_count", 64'(n_fim), 64'd2);
      verifica("active_pixels_frame", 64'(n_ativo), 64'd160);
      verifica("area_outside_visible", 64'(viol), 64'd0);
      verifica("pulse_without_pixelEn", 64'(viol_pulso), 64'd0);
      verifica("div1_pixelEn_low", 64'(b_pix_low), 64'd0);
      verifica("div1_first_line_k", 64'(b_lin1), 64'd25);
      verifica("div1_line_period", 64'(b_lin2 - b_lin1), 64'd25);

      // Park mid-frame inside both sync pulses, then hit reset between clock edges.
      achou = 1'b0;
      for (int i = 0; i < 2000 && !achou; i++) begin
         ciclo();
         if (va.linha == 10'd12 && va.coluna == 10'd19) achou = 1'b1;
      end
      verifica("reach_mid_frame", 64'(achou), 64'd1);
      verifica("mid_hsync_low", 64'(va.hsync), 64'd0);
      verifica("mid_vsync_low", 64'(va.vsync), 64'd0);
      #2 rst = 1'b1;
      #1 verifica_reset("rst_async");
      repeat (3) @(negedge clk);
      verifica_reset("rst_hold");
      rst = 1'b0;

      k = 0;
      achou = 1'b0;
      for (int i = 1; i <= 1000 && !achou; i++) begin
         ciclo();
         if (va.inicioQuadro) begin
            achou = 1'b1;
            k = i;
         end
      end
      verifica("rst_inicio_k", 64'(k), 64'd850);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/vga_sincronismo.md
# vga_sincronismo

VGA 640x480@60 Hz timing generator that produces the pixel coordinates (`linha`, `coluna`), the `areaAtiva` qualifier and the `hsync`/`vsync` pulses. The ship renderers consume these signals, so this block sits at the head of the video path. A single `clk` domain is used: the system clock is divided internally into a pixel-rate enable. When configured, the block also shadows the ship-position vectors once per frame so renderers never change mid-frame.

## Interface
Parameters:
- `DIV`, 2: system clocks per pixel (50 MHz to 25 MHz); legal range 1..16.
- `H_VIS`, 640: visible columns.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_VIS`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `areaAtiva` out 1: high while `coluna < H_VIS` and `linha < V_VIS`.
- `coluna` out 10: current horizontal pixel count, 0..H_TOT-1.
- `linha` out 10: current vertical line count, 0..V_TOT-1.
- `pixelEn` out 1: one-`clk` pulse in the first cycle of each new pixel.
- `inicioQuadro` out 1: one-`clk` pulse when the counters reach (0,0).
- `fimVisivel` out 1: one-`clk` pulse when `linha` becomes `V_VIS` with `coluna` = 0, marking the start of vertical blanking.
- `posicoesIn` in 64: ship-position vector from game logic. Present only with the macro.
- `posicoesQuadro` out 64: frame-stable copy of `posicoesIn`. Present only with the macro.

## Operation
- `H_TOT = H_VIS+H_FP+H_SYNC+H_BP` (default 800). `V_TOT` is defined the same way (default 525). Elaboration fails if either exceeds 1024.
- Divider: `divCnt` counts 0..DIV-1 and wraps. A pixel tick occurs when `divCnt == DIV-1`. With DIV=1 every cycle is a tick.
- On each tick:
  - `coluna` increments.
  - When `coluna` = H_TOT-1, `coluna` wraps to 0 and `linha` increments.
  - When `linha` = V_TOT-1 and `coluna` wraps, `linha` also wraps to 0.
- `hsync` is low while `coluna` is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] (default 656..751).
- `vsync` is low while `linha` is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] (default 490..491).
- All outputs are registered. `hsync`, `vsync`, `areaAtiva`, `pixelEn`, `inicioQuadro` and `fimVisivel` are decoded from the next-counter values, so they change on the same `clk` edge as `coluna`/`linha`. There is no skew between coordinates and qualifiers.
- Reset values:
  - `coluna` = 0, `linha` = 0, `divCnt` = 0.
  - `hsync` = 1, `vsync` = 1.
  - `areaAtiva` = 0, `pixelEn` = 0, `inicioQuadro` = 0, `fimVisivel` = 0.
  - `posicoesQuadro` = 0.
- After reset, position (0,0) of the first frame is blanked. Normal timing starts at the first tick, which moves the counters to (1,0) with `areaAtiva` = 1.
- Reset asserted mid-frame returns everything to the reset state immediately. No partial sync pulse is stretched.

## Timing
- Tick period is DIV `clk`. Line period is H_TOT·DIV `clk` (1600 by default). Frame period is H_TOT·V_TOT·DIV `clk` (840000 by default).
- `pixelEn`, `inicioQuadro` and `fimVisivel` are each high for exactly one `clk`.
- `inicioQuadro` and `fimVisivel` always coincide with `pixelEn`.
- Latency from counter change to qualifier change is 0 `clk`. Both are registered on the same edge.
- `coluna` and `linha` hold their values for DIV `clk` between ticks.

## Configuration
- Macro `VGA_SINC_QUADRO_EN`.
- Defined: the `posicoesIn` and `posicoesQuadro` ports exist. `posicoesQuadro` loads `posicoesIn` on the same edge that raises `fimVisivel`, and holds it otherwise. Renderers therefore see one stable vector for the whole visible region. A change to `posicoesIn` during visible lines appears at the next blanking interval.
- Undefined: both ports and the 64-bit register are absent. All other behaviour is identical.

## Structure
- Shared package `vga_pkg` holds:
  - default timing constants;
  - coordinate width (10);
  - ship-vector width (64) and the 4-bit field offsets used by the renderers.
- Sub-module `vga_contador`: a parameterised modulo-N counter with enable, asynchronous reset and a wrap output. It is instantiated twice, horizontal (enable = tick) and vertical (enable = tick AND horizontal wrap).

## Test plan
- Reset, then run 2 frames with defaults:
  - `hsync` low for exactly 192 `clk` per line, starting at `coluna` = 656.
  - `vsync` low for 3200 `clk`, starting at `linha` = 490.
  - `inicioQuadro` period is 840000 `clk`.
- Count `areaAtiva`&&`pixelEn` over one full frame after the first: exactly 307200. `areaAtiva` is never high with `coluna` ≥ 640 or `linha` ≥ 480.
- Wrap check:
  - tick at (799,524) produces (0,0) with `inicioQuadro` = 1;
  - tick at (799,479) produces (0,480) with `fimVisivel` = 1.
- Assert `rst` for 3 `clk` at `linha` = 200, `coluna` = 300: all outputs take their reset values asynchronously. The next `inicioQuadro` follows 840000 `clk` after release, adjusted for the blanked (0,0) start.
- DIV=1 build: `pixelEn` is high on every cycle after the first, and the line period is 800 `clk`.
- With `VGA_SINC_QUADRO_EN`:
  - drive `posicoesIn` = 64'h0000_0001_2345_6781 at `linha` = 100: `posicoesQuadro` stays unchanged until the `fimVisivel` edge, then equals the new value;
  - a change at `linha` = 481 first appears at the following frame's `fimVisivel`.
